// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   IMemAddrWidth  : byte-address width of the instruction memory
//   MaxWords       : largest image (in 32-bit words) that fits in memory
//   HeaderBytes    : length of the little-endian word-count header
//   word           : 32-bit memory word
//   mem_width_t    : access width presented to the memory
//   loader_state_e : loader FSM states
package imem_loader_pkg;

  localparam int IMemAddrWidth = 10;
  localparam int MaxWords      = 2 ** (IMemAddrWidth - 2);
  localparam int WordCntWidth  = IMemAddrWidth - 1;  // holds 0..MaxWords
  localparam int HeaderBytes   = 4;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream handshake between a UART receiver and the loader.
//   rx_data  : byte from the receiver
//   rx_valid : rx_data holds a byte
//   rx_ready : loader can take a byte; transfer on clk edge with valid && ready
// Modports: master = byte source, slave = loader.
interface imem_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/imem_loader_timeout.sv
// Idle counter for the loader.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : a byte was accepted this cycle; restart the count
//   enable     : count idle cycles in this cycle
//   expired    : TimeoutCycles idle cycles have elapsed since the last clear
module loader_timeout #(
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] count_q;

  assign expired = (count_q == CntWidth'(TimeoutCycles));

  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      // Saturate so the expired flag cannot wrap back to idle.
      count_q <= count_q + CntWidth'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a boot image from a UART into instruction memory while the core
// is held in reset.
// Image: 4-byte little-endian word count N, then N little-endian words.
//   clk, reset   : clock, asynchronous active-high reset
//   rx           : byte stream handshake (slave side)
//   write_enable : memory write strobe, one cycle per word
//   width        : memory access width (always WORD)
//   sign_extend  : memory sign extension (always 0)
//   address      : memory byte address
//   data_in      : memory write data
//   cpu_hold     : keeps the core in reset until the image is loaded
//   done         : image completely written (held until reset)
//   error        : load aborted (bad length or timeout, held until reset)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_loader_if.slave             rx,
  output logic                     write_enable,
  output mem_width_t               width,
  output logic                     sign_extend,
  output logic [IMemAddrWidth-1:0] address,
  output word                      data_in,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  loader_state_e            state_q, state_d;
  logic [1:0]               byte_cnt_q, byte_cnt_d;
  logic [WordCntWidth-1:0]  word_cnt_q, word_cnt_d;
  logic [WordCntWidth-1:0]  n_q, n_d;
  logic [IMemAddrWidth-1:0] address_q, address_d;
  word                      data_q, data_d;

  logic ready_c;
  logic rx_accept;
  logic timeout_en;
  logic timeout_expired;
  word  shifted;
  logic [WordCntWidth-1:0]  word_cnt_inc;

  // Bytes arrive LSB first: each new byte enters at the top, so after four
  // bytes the first one sits in [7:0].
  assign shifted      = {rx.rx_data, data_q[31:8]};
  assign word_cnt_inc = word_cnt_q + WordCntWidth'(1);

  // rx_ready is forced low while reset is asserted even though the held
  // state is LEN.
  assign rx.rx_ready = ready_c && !reset;
  assign rx_accept   = rx.rx_valid && rx.rx_ready;

  // An empty header never times out; the timeout starts with the first byte.
  assign timeout_en = ((state_q == ST_LEN) && (byte_cnt_q != 2'd0)) ||
                      (state_q == ST_DATA);

  assign width       = MEM_WORD;
  assign sign_extend = 1'b0;
  assign address     = address_q;
  assign data_in     = data_q;

  loader_timeout #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_accept),
    .enable  (timeout_en),
    .expired (timeout_expired)
  );

  // NOTE: every register, including the data buffer, is reset so a load
  // interrupted mid-word leaves no stale partial word behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LEN;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      n_q        <= '0;
      address_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      n_q        <= n_d;
      address_q  <= address_d;
      data_q     <= data_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    n_d          = n_q;
    address_d    = address_q;
    data_d       = data_q;
    ready_c      = 1'b0;
    write_enable = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    error        = 1'b0;

    unique case (state_q)
      ST_LEN: begin
        ready_c = 1'b1;
        if (rx.rx_valid) begin
          data_d     = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'(HeaderBytes - 1)) begin
            byte_cnt_d = '0;
            if (shifted == '0) begin
              state_d = ST_DONE;
            end else if (shifted > word'(MaxWords)) begin
              state_d = ST_ERROR;
            end else begin
              state_d    = ST_DATA;
              n_d        = shifted[WordCntWidth-1:0];
              word_cnt_d = '0;
              address_d  = '0;
            end
          end
        end else if (timeout_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_DATA: begin
        ready_c = 1'b1;
        if (rx.rx_valid) begin
          data_d     = shifted;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end
        end else if (timeout_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_WRITE: begin
        write_enable = 1'b1;
        word_cnt_d   = word_cnt_inc;
        if (word_cnt_inc == n_q) begin
          // Address stays on the last word so it never wraps past memory.
          state_d = ST_DONE;
        end else begin
          state_d   = ST_DATA;
          address_d = address_q + IMemAddrWidth'(4);
        end
      end

      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end

      ST_ERROR: begin
        error = 1'b1;
      end

      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

endmodule
